// File: rtl/fifo_pkg.sv
// Shared definitions for fifo_wrapper and its drain master: register map,
// status bit positions and the drain FSM state encoding.
package fifo_pkg;

   // Avalon-MM register map of fifo_wrapper
   localparam logic [1:0] ADDR_STATUS = 2'b00;
   localparam logic [1:0] ADDR_READ   = 2'b01;
   localparam logic [1:0] ADDR_WRITE  = 2'b10;

   // Bit positions inside the STATUS word
   localparam int STAT_FULL  = 1;
   localparam int STAT_EMPTY = 0;

   // Drain master states
   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      READ,
      WAIT,
      HOLD
   } state_t;

endpackage

// File: rtl/fifo_drain_master.sv
// Avalon-MM master that empties fifo_wrapper one word at a time and hands
// each word to a valid/ready stream. At most one word is in flight.
//
// Stream handshake: out_valid rises with out_data already stable, both stay
// unchanged until the edge where out_valid && out_ready (the transfer edge);
// out_ready while out_valid is low has no effect.
module fifo_drain_master
   import fifo_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int READ_LATENCY = 1,   // 1..3
   parameter int CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   output logic [1:0]           avalon_address,
   output logic                 avalon_read,
   output logic                 avalon_write,
   output logic [WIDTH-1:0]     avalon_writedata,
   input  logic [WIDTH-1:0]     avalon_readdata,
   input  logic [1:0]           avalon_status,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CNT_WIDTH-1:0] drained_count,
   output logic                 full_seen,
   input  logic                 full_seen_clr,
   output state_t               dbg_state
);

   // Counter reload: WAIT lasts READ_LATENCY cycles in total
   localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

   state_t     state_q;
   state_t     state_d;
   logic [1:0] lat_q;
   logic       xfer;
   logic       capture;

   assign xfer    = out_valid && out_ready;
   assign capture = (state_q == WAIT) && (lat_q == 2'd0);

   // This master never writes the wrapper
   assign avalon_write     = 1'b0;
   assign avalon_writedata = '0;
   assign dbg_state        = state_q;

   // Next-state logic; enable only matters in IDLE and CHECK so an issued read always completes
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (enable) state_d = CHECK;
         CHECK: begin
            if (!enable)
               state_d = IDLE;
            else if (!avalon_status[STAT_EMPTY])
               state_d = READ;
         end
         READ:  state_d = WAIT;
         WAIT:  if (lat_q == 2'd0) state_d = HOLD;
         HOLD:  if (xfer) state_d = enable ? CHECK : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register plus bus outputs registered from the next state so the strobe lines up with READ
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         avalon_address <= ADDR_STATUS;
         avalon_read    <= 1'b0;
      end else begin
         state_q        <= state_d;
         avalon_read    <= (state_d == READ);
         avalon_address <= (state_d == READ) ? ADDR_READ : ADDR_STATUS;
      end
   end

   // Read latency counter, loaded while the strobe is on the bus and counted down in WAIT
   always_ff @(posedge clk) begin
      if (!reset)
         lat_q <= 2'd0;
      else if (state_q == READ)
         lat_q <= LAT_LOAD;
      else if ((state_q == WAIT) && (lat_q != 2'd0))
         lat_q <= lat_q - 2'd1;
   end

   // Stream output register and delivered-word counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_data      <= '0;
         out_valid     <= 1'b0;
         drained_count <= '0;
      end else if (capture) begin
         out_data  <= avalon_readdata;
         out_valid <= 1'b1;
      end else if (xfer) begin
         out_valid     <= 1'b0;
         drained_count <= drained_count + CNT_WIDTH'(1);
      end
   end

   // Sticky full flag; a full sample in the same cycle as a clear keeps it set
   always_ff @(posedge clk) begin
      if (!reset)
         full_seen <= 1'b0;
      else if (avalon_status[STAT_FULL])
         full_seen <= 1'b1;
      else if (full_seen_clr)
         full_seen <= 1'b0;
   end

endmodule

// File: tb/tb_fifo_drain_master.sv
// Bench for fifo_drain_master: behavioural fifo_wrapper slave, stream
// monitor with an expected-word queue, full_seen vector table, directed
// corner sequences and a randomized drain phase.
module tb_fifo_drain_master;
   import fifo_pkg::*;

   localparam int W  = 8;
   localparam int CW = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic          enable = 1'b0;
   logic [1:0]    avalon_address;
   logic          avalon_read;
   logic          avalon_write;
   logic [W-1:0]  avalon_writedata;
   logic [W-1:0]  avalon_readdata = '0;
   logic [1:0]    avalon_status;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] drained_count;
   logic          full_seen;
   logic          full_seen_clr = 1'b0;
   state_t        dbg_state;

   fifo_drain_master #(.WIDTH(W), .READ_LATENCY(1), .CNT_WIDTH(CW)) dut (
      .clk              (clk),
      .reset            (reset),
      .enable           (enable),
      .avalon_address   (avalon_address),
      .avalon_read      (avalon_read),
      .avalon_write     (avalon_write),
      .avalon_writedata (avalon_writedata),
      .avalon_readdata  (avalon_readdata),
      .avalon_status    (avalon_status),
      .out_data         (out_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .drained_count    (drained_count),
      .full_seen        (full_seen),
      .full_seen_clr    (full_seen_clr),
      .dbg_state        (dbg_state)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- fifo_wrapper model (depth 16, latency 1) ----------------
   logic [W-1:0] mem_q[$];
   logic force_full = 1'b0;
   int strobe_cnt = 0;
   int underflow  = 0;
   int write_seen = 0;
   int cyc        = 0;

   assign avalon_status = {(mem_q.size() == 16) || force_full, (mem_q.size() == 0)};

   always @(posedge clk) begin
      cyc++;
      if (avalon_write) write_seen++;
      if (avalon_read) begin
         strobe_cnt++;
         if (avalon_address != ADDR_READ || mem_q.size() == 0)
            underflow++;
         else
            avalon_readdata <= mem_q.pop_front();
      end
   end

   // ---------------- scoreboard / stream monitor ----------------
   logic [W-1:0] exp_q[$];
   int model_cnt = 0;
   int valid_cyc = 0;
   int xfer_cyc_q[$];
   logic prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;

   always @(negedge clk) begin
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev_data));
         end
         if (out_valid) valid_cyc++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL extra_word: got %0h expected no word", out_data);
            end else begin
               chk("word", 32'(out_data), 32'(exp_q.pop_front()));
            end
            model_cnt++;
            xfer_cyc_q.push_back(cyc);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [W-1:0] d);
      mem_q.push_back(d);
      exp_q.push_back(d);
   endtask

   task automatic wait_exp(input int left, input int budget, input string name);
      int k = 0;
      while (exp_q.size() > left && k < budget) begin
         tick();
         k++;
      end
      chk(name, 32'(exp_q.size()), 32'(left));
   endtask

   task automatic wait_read(input int budget, input string name);
      int k = 0;
      tick();
      while (!avalon_read && k < budget) begin
         tick();
         k++;
      end
      chk(name, 32'(avalon_read), 32'd1);
   endtask

   typedef struct packed {
      logic full;
      logic clr;
      logic exp_fs;
   } fs_vec_t;

   fs_vec_t fs_tab[9];

   // ---------------- main sequence ----------------
   initial begin
      int s0;
      int v0;
      fs_tab[0] = '{full: 1'b0, clr: 1'b0, exp_fs: 1'b0};
      fs_tab[1] = '{full: 1'b1, clr: 1'b0, exp_fs: 1'b1};
      fs_tab[2] = '{full: 1'b0, clr: 1'b0, exp_fs: 1'b1};
      fs_tab[3] = '{full: 1'b0, clr: 1'b1, exp_fs: 1'b0};
      fs_tab[4] = '{full: 1'b1, clr: 1'b1, exp_fs: 1'b1};
      fs_tab[5] = '{full: 1'b0, clr: 1'b1, exp_fs: 1'b0};
      fs_tab[6] = '{full: 1'b1, clr: 1'b0, exp_fs: 1'b1};
      fs_tab[7] = '{full: 1'b1, clr: 1'b1, exp_fs: 1'b1};
      fs_tab[8] = '{full: 1'b0, clr: 1'b1, exp_fs: 1'b0};

      // Reset and idle
      reset  = 1'b0;
      enable = 1'b1;
      tick(2);
      chk("rst_addr", 32'(avalon_address), 32'd0);
      chk("rst_read", 32'(avalon_read), 32'd0);
      chk("rst_write", 32'(avalon_write), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_count", 32'(drained_count), 32'd0);
      chk("rst_full", 32'(full_seen), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      reset = 1'b1;
      tick();
      s0 = strobe_cnt;
      tick(20);
      chk("empty_no_strobe", 32'(strobe_cnt), 32'(s0));
      chk("empty_state", 32'(dbg_state), 32'(CHECK));

      // full_seen vector table, FSM parked in IDLE
      enable = 1'b0;
      tick(2);
      for (int i = 0; i < 9; i++) begin
         force_full    = fs_tab[i].full;
         full_seen_clr = fs_tab[i].clr;
         tick();
         chk($sformatf("fs_vec%0d", i), 32'(full_seen), 32'(fs_tab[i].exp_fs));
      end
      force_full    = 1'b0;
      full_seen_clr = 1'b0;

      // Basic drain
      out_ready = 1'b1;
      push(8'hA5);
      push(8'h5A);
      push(8'hFF);
      xfer_cyc_q.delete();
      v0 = valid_cyc;
      s0 = strobe_cnt;
      enable = 1'b1;
      wait_exp(0, 60, "basic_done");
      tick(10);
      chk("basic_count", 32'(drained_count), 32'(model_cnt));
      chk("basic_count3", 32'(drained_count), 32'd3);
      chk("basic_strobes", 32'(strobe_cnt - s0), 32'd3);
      chk("basic_valid_cycles", 32'(valid_cyc - v0), 32'd3);
      chk("basic_xfers", 32'(xfer_cyc_q.size()), 32'd3);
      if (xfer_cyc_q.size() == 3) begin
         chk("basic_gap1", 32'(xfer_cyc_q[1] - xfer_cyc_q[0]), 32'd4);
         chk("basic_gap2", 32'(xfer_cyc_q[2] - xfer_cyc_q[1]), 32'd4);
      end

      // Backpressure
      out_ready = 1'b0;
      s0 = strobe_cnt;
      push(8'h11);
      push(8'h22);
      begin
         int k = 0;
         while (!out_valid && k < 20) begin
            tick();
            k++;
         end
      end
      chk("bp_valid_rise", 32'(out_valid), 32'd1);
      tick(10);
      chk("bp_valid_held", 32'(out_valid), 32'd1);
      chk("bp_data_held", 32'(out_data), 32'h11);
      chk("bp_one_strobe", 32'(strobe_cnt - s0), 32'd1);
      out_ready = 1'b1;
      wait_exp(0, 40, "bp_done");
      tick(3);
      chk("bp_strobes", 32'(strobe_cnt - s0), 32'd2);
      chk("bp_count", 32'(drained_count), 32'(model_cnt));

      // Enable drop in the cycle after the strobe
      s0 = strobe_cnt;
      push(8'h31);
      push(8'h32);
      push(8'h33);
      wait_read(20, "ed_strobe");
      tick();
      enable = 1'b0;
      wait_exp(2, 20, "ed_word");
      tick(4);
      chk("ed_state", 32'(dbg_state), 32'(IDLE));
      chk("ed_fifo_left", 32'(mem_q.size()), 32'd2);
      chk("ed_strobes", 32'(strobe_cnt - s0), 32'd1);
      chk("ed_count", 32'(drained_count), 32'(model_cnt));
      enable = 1'b1;
      wait_exp(0, 40, "ed_rest");
      tick(3);

      // Full flag with a 16-deep preload
      enable = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      model_cnt = 0;
      for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
      tick();
      chk("full_set", 32'(full_seen), 32'd1);
      full_seen_clr = 1'b1;
      tick();
      full_seen_clr = 1'b0;
      chk("full_clr_loses", 32'(full_seen), 32'd1);
      enable = 1'b1;
      wait_exp(15, 20, "full_first");
      full_seen_clr = 1'b1;
      tick();
      full_seen_clr = 1'b0;
      chk("full_cleared", 32'(full_seen), 32'd0);
      wait_exp(0, 100, "full_drain");
      tick(3);
      chk("full_count16", 32'(drained_count), 32'd16);

      // Reset while waiting for read data
      push(8'h41);
      push(8'h42);
      wait_read(20, "rm_strobe");
      tick();
      chk("rm_in_wait", 32'(dbg_state), 32'(WAIT));
      reset = 1'b0;
      tick();
      chk("rm_valid", 32'(out_valid), 32'd0);
      chk("rm_count", 32'(drained_count), 32'd0);
      reset = 1'b1;
      model_cnt = 0;
      void'(exp_q.pop_front());
      wait_exp(0, 30, "rm_resume");
      tick(3);
      chk("rm_count_after", 32'(drained_count), 32'(model_cnt));

      // Randomized traffic, enable and backpressure
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0 && mem_q.size() < 16) push(8'($urandom_range(0, 255)));
         enable    = ($urandom_range(0, 9) != 0);
         out_ready = ($urandom_range(0, 1) != 0);
         tick();
      end
      enable    = 1'b1;
      out_ready = 1'b1;
      wait_exp(0, 200, "rand_drain");
      tick(3);
      chk("rand_count", 32'(drained_count), 32'(model_cnt % (1 << CW)));
      chk("rand_fifo_empty", 32'(mem_q.size()), 32'd0);

      chk("no_bad_reads", 32'(underflow), 32'd0);
      chk("no_writes", 32'(write_seen), 32'd0);
      chk("writedata_zero", 32'(avalon_writedata), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/fifo_drain_master.md
Name: fifo_drain_master

Overview:
- Avalon-MM master that sits directly downstream of fifo_wrapper and empties it.
- Polls the wrapper's status, issues single-word reads from the FIFO_READ address, and presents each word on a valid/ready stream to the next consumer.
- Keeps one word in flight at most.
- Counts delivered words and flags whenever the FIFO is seen full.

Parameters:
- WIDTH, 8: data width. Must match fifo_wrapper WIDTH.
- READ_LATENCY, 1: cycles from the read-strobe clock edge until avalon_readdata is valid. Legal range 1..3.
- CNT_WIDTH, 16: width of drained_count.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  1 = drain the FIFO; 0 = finish the current word, then idle.
- avalon_address  out  2  00 STATUS, 01 FIFO_READ, 10 FIFO_WRITE.
- avalon_read  out  1  one-cycle read strobe.
- avalon_write  out  1  tied 0.
- avalon_writedata  out  WIDTH  tied 0.
- avalon_readdata  in  WIDTH  FIFO data from the wrapper.
- avalon_status  in  2  [1] full, [0] empty. Live from the wrapper.
- out_data  out  WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- drained_count  out  CNT_WIDTH  number of words handed off.
- full_seen  out  1  sticky; set when avalon_status[1]==1 is sampled.
- full_seen_clr  in  1  clears full_seen.

Behaviour:
- Reset (reset==0 at a clock edge). Values after the edge:
  - State = IDLE.
  - avalon_address = 00, avalon_read = 0.
  - out_valid = 0, out_data = 0.
  - drained_count = 0, full_seen = 0, latency counter = 0.
- Reset mid-operation discards any captured or pending word. No read is re-issued.
- All outputs are registered.
- IDLE:
  - avalon_address = 00, no strobe.
  - Go to CHECK when enable==1.
- CHECK:
  - avalon_address = 00.
  - If enable==0, go to IDLE.
  - Else if avalon_status[0]==0 (not empty), go to READ.
  - Else stay in CHECK.
- READ:
  - Exactly one cycle with avalon_address = 01 and avalon_read = 1.
  - Then go to WAIT and load the latency counter with READ_LATENCY-1.
- WAIT:
  - avalon_address = 00, avalon_read = 0.
  - When the counter reaches 0, capture avalon_readdata into out_data, set out_valid = 1 (visible next cycle), and go to HOLD.
  - Otherwise decrement the counter.
- HOLD:
  - out_valid and out_data stay stable until out_ready==1 while out_valid==1. That is the transfer cycle.
  - On the transfer edge:
    - out_valid goes to 0.
    - drained_count increments, wrapping modulo 2^CNT_WIDTH.
    - Next state is CHECK if enable==1, else IDLE.
  - out_ready high while out_valid==0 has no effect.
- enable handling:
  - enable is sampled only in IDLE and CHECK.
  - A read already issued always completes through HOLD. No word is dropped because enable falls.
- Timing guarantees:
  - At least 2 cycles (READ + WAIT) separate a strobe from the next CHECK, so the wrapper's empty flag is settled when it is re-sampled.
  - Throughput is one word per (READ_LATENCY + 3) cycles when out_ready is held high.
- Empty FIFO: never strobe avalon_read while avalon_status[0]==1, so an underflow read is impossible.
- full_seen:
  - Set on any edge where avalon_status[1]==1, in every state except reset.
  - full_seen_clr==1 clears it. If clear and set occur in the same cycle, set wins.
- The block never drives avalon_write=1.

Decomposition:
- Shared package fifo_pkg holds:
  - Address constants ADDR_STATUS=2'b00, ADDR_READ=2'b01, ADDR_WRITE=2'b10.
  - Status bit indices STAT_FULL=1, STAT_EMPTY=0.
  - State enum {IDLE, CHECK, READ, WAIT, HOLD}.
  - fifo_wrapper is refactored to use the same package.
- No sub-module is needed. The output register plus handshake is small enough to stay inline.

Test Plan:
- Reset and idle:
  - Hold reset=0 for 2 cycles with enable=1.
  - All outputs are 0.
  - After reset=1 with the FIFO empty, the block sits in CHECK and avalon_read never pulses over 20 cycles.
- Basic drain:
  - Preload the wrapper with A5, 5A, FF. Set enable=1 and out_ready=1.
  - out_data shows A5, 5A, FF in order, one valid cycle each, 4 cycles apart.
  - drained_count=3. Then no further strobes.
- Backpressure:
  - Preload 11, 22. Hold out_ready=0 for 10 cycles after out_valid rises.
  - out_data stays 11 and no second strobe is issued.
  - Release out_ready: 22 follows.
- Enable drop mid-word:
  - Deassert enable the cycle after the avalon_read strobe.
  - The word still completes HOLD.
  - The state then returns to IDLE and the remaining FIFO content is untouched.
- Full flag:
  - Fill the wrapper to 16 entries before enable.
  - full_seen=1.
  - full_seen_clr with status still full keeps it 1 (set wins).
  - Clearing after the first read clears it.
  - Draining all 16 words gives drained_count=16.
- Reset mid-operation:
  - Assert reset=0 during WAIT.
  - Next edge: out_valid=0 and drained_count=0.
  - After release, draining resumes from the next FIFO word (the in-flight word is lost).
